// File: rtl/addsub_pkg.sv
// Shared types and helpers for the round-robin add/subtract arbiter.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_REQ       = 8;
    localparam int IDX_W         = 3;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid scanning upward from ptr, wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 nreq);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k < nreq && !r.found && valid[idx]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between client FSMs (master) and the shared ALU arbiter (slave).
interface addsub_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_sub;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_dout;
    logic                  rsp_zero;

    modport master (
        output req_valid, req_sub, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_dout, rsp_zero
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_dout, rsp_zero
    );
endinterface

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit add/subtract with zero detect; subtraction is a + ~b + 1.
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             do_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dout,
    output logic             result_is_zero
);
    always_comb begin
        if (op_e'(do_sub) == OP_SUB) dout = a + ~b + WIDTH'(1);
        else                         dout = a + b;
    end

    assign result_is_zero = (dout == '0);
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin share of one add/subtract unit among NREQ requesters with a
// single registered, id-tagged response channel.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    addsub_arbiter_if.slave     bus,
    output logic [15:0]         op_count
);
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] ptr_next;
    logic [IDW-1:0]   gnt_id;
    rr_pick_t         pick;
    logic             can_issue;
    logic             issue;
    logic [WIDTH-1:0] a_sel, b_sel, dout;
    logic             sub_sel, zero;

    assign pick      = rr_pick(MAX_REQ'(bus.req_valid), ptr, NREQ);
    assign gnt       = pick.idx;
    assign gnt_id    = gnt[IDW-1:0];
    assign can_issue = !bus.rsp_valid || bus.rsp_ready;
    assign issue     = can_issue && pick.found && !reset;
    assign ptr_next  = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (issue) bus.req_ready[gnt_id] = 1'b1;
    end

    assign a_sel   = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
    assign b_sel   = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
    assign sub_sel = bus.req_sub[gnt_id];

    addsub_unit #(.WIDTH(WIDTH)) u_alu (
        .do_sub         (sub_sel),
        .a              (a_sel),
        .b              (b_sel),
        .dout           (dout),
        .result_is_zero (zero)
    );

    // Response data only moves on a transfer; a drain without issue just drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_dout  <= '0;
            bus.rsp_zero  <= 1'b0;
            op_count      <= '0;
            ptr           <= '0;
        end else if (issue) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= gnt_id;
            bus.rsp_dout  <= dout;
            bus.rsp_zero  <= zero;
            op_count      <= op_count + 16'd1;
            ptr           <= ptr_next;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: vector table, directed corner sequences and random
// traffic scored against a cycle-level reference model.
module tb_addsub_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] op_count;

    addsub_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    addsub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_ptr, m_id, m_dout, m_cnt;
    bit m_vld, m_zero;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit sub, input int a, input int b);
        bus.req_valid[i]              = v;
        bus.req_sub[i]                = sub;
        bus.req_a[i*WIDTH +: WIDTH]   = WIDTH'(a);
        bus.req_b[i*WIDTH +: WIDTH]   = WIDTH'(b);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
    endtask

    // One clock: check current outputs against the model, then advance both.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        int  g, a, b, idx;
        bit  found;
        #1;
        exp_rdy = '0;
        found   = 0;
        g       = 0;
        if (!rst && (!m_vld || bus.rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && bus.req_valid[idx]) begin
                    found = 1;
                    g     = idx;
                end
            end
        end
        if (found) exp_rdy[g] = 1'b1;
        chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
        chk("rsp_valid", int'(bus.rsp_valid), int'(m_vld));
        chk("rsp_id",    int'(bus.rsp_id),    m_id);
        chk("rsp_dout",  int'(bus.rsp_dout),  m_dout);
        chk("rsp_zero",  int'(bus.rsp_zero),  int'(m_zero));
        chk("op_count",  int'(op_count),      m_cnt);
        a = int'(bus.req_a[g*WIDTH +: WIDTH]);
        b = int'(bus.req_b[g*WIDTH +: WIDTH]);
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_id = 0; m_dout = 0; m_zero = 0; m_cnt = 0; m_ptr = 0;
        end else if (found) begin
            m_vld  = 1;
            m_id   = g;
            m_dout = (bus.req_sub[g] ? (a - b) : (a + b)) & MASK;
            m_zero = (m_dout == 0);
            m_cnt  = (m_cnt + 1) % 65536;
            m_ptr  = (g + 1) % NREQ;
        end else if (bus.rsp_ready) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        int id; bit sub; int a; int b; int dout; bit zero;
    } vec_t;

    vec_t vecs[8];
    int   saved_id;

    initial begin
        vecs[0] = '{0, 1, 8'h03, 8'h03, 8'h00, 1};
        vecs[1] = '{1, 1, 8'h03, 8'h04, 8'hFF, 0};
        vecs[2] = '{2, 0, 8'hFD, 8'h03, 8'h00, 1};
        vecs[3] = '{3, 0, 8'hFD, 8'h04, 8'h01, 0};
        vecs[4] = '{0, 0, 8'hFF, 8'h01, 8'h00, 1};
        vecs[5] = '{1, 1, 8'h00, 8'h01, 8'hFF, 0};
        vecs[6] = '{2, 0, 8'h7F, 8'h01, 8'h80, 0};
        vecs[7] = '{3, 1, 8'h80, 8'h80, 8'h00, 1};

        m_ptr = 0; m_id = 0; m_dout = 0; m_cnt = 0; m_vld = 0; m_zero = 0;
        bus.req_valid = '0; bus.req_sub = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_op_count",  int'(op_count), 0);

        // Single-requester vector table
        for (int k = 0; k < 8; k++) begin
            clear_reqs();
            set_req(vecs[k].id, 1, vecs[k].sub, vecs[k].a, vecs[k].b);
            cycle();
            chk("vec_valid", int'(bus.rsp_valid), 1);
            chk("vec_id",    int'(bus.rsp_id),    vecs[k].id);
            chk("vec_dout",  int'(bus.rsp_dout),  vecs[k].dout);
            chk("vec_zero",  int'(bus.rsp_zero),  int'(vecs[k].zero));
            if (k == 0) chk("vec_first_count", int'(op_count), 1);
        end
        clear_reqs();
        cycle();

        // All four continuously valid: rotation 0,1,2,3,...
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i[0], 16 * i, i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_id", int'(bus.rsp_id), k % NREQ);
        end

        // Backpressure for 3 cycles then release
        saved_id = int'(bus.rsp_id);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready_zero", int'(bus.req_ready), 0);
            chk("bp_id_stable",  int'(bus.rsp_id), saved_id);
            chk("bp_valid",      int'(bus.rsp_valid), 1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", int'(bus.req_ready), 1 << ((saved_id + 1) % NREQ));
        cycle();
        chk("bp_release_id", int'(bus.rsp_id), (saved_id + 1) % NREQ);

        // Pointer wrap: only req2 valid with pointer at 3
        do_reset();
        clear_reqs();
        set_req(2, 1, 0, 5, 6);
        cycle();
        chk("wrap_first", int'(bus.rsp_id), 2);
        cycle();
        chk("wrap_second", int'(bus.rsp_id), 2);
        set_req(3, 1, 1, 9, 9);
        cycle();
        chk("wrap_ptr3", int'(bus.rsp_id), 3);

        // Reset while a response is held and requests are pending
        clear_reqs();
        set_req(1, 1, 0, 1, 1);
        set_req(3, 1, 0, 2, 2);
        bus.rsp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_ready_zero", int'(bus.req_ready), 0);
        cycle();
        rst = 1'b0;
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_op_count",  int'(op_count), 0);
        bus.rsp_ready = 1'b1;
        cycle();
        chk("rst_first_grant", int'(bus.rsp_id), 1);

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                int a;
                a = int'($urandom_range(0, MASK));
                set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, a,
                        ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, MASK)));
            end
            bus.rsp_ready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
